// File: rtl/hid_target_if.sv
// HID byte channel between the MCU SPI interface and the HID target.
//   data_in_strobe : one-cycle pulse, a new HID byte is on data_in
//   data_in_start  : with the strobe, marks the command byte
//   data_in        : received byte
//   data_out       : reply byte shifted back to the MCU
// master = SPI interface side, slave = HID target side.
interface hid_target_if;
    logic       data_in_strobe;
    logic       data_in_start;
    logic [7:0] data_in;
    logic [7:0] data_out;

    modport master (
        output data_in_strobe,
        output data_in_start,
        output data_in,
        input  data_out
    );

    modport slave (
        input  data_in_strobe,
        input  data_in_start,
        input  data_in,
        output data_out
    );
endinterface

// File: rtl/hid_target.sv
// HID target: decodes keyboard, mouse and joystick messages arriving on the
// HID byte channel and produces the reply byte for the MCU.
//   clk, reset        : core clock, synchronous active-high reset
//   hid (slave)       : byte channel (strobe/start/data in, reply data out)
//   kbd_strobe/code/release : one-cycle key event
//   mouse_buttons/dx/dy     : button state and saturating motion accumulators
//   mouse_clr         : core consumed the motion, clears both accumulators
//   joy0, joy1        : joystick states
// Every output is a register.
module hid_target #(
    parameter logic [7:0]  VERSION = 8'h01,
    parameter int unsigned MOUSE_W = 10
) (
    input  logic               clk,
    input  logic               reset,
    hid_target_if.slave        hid,
    output logic               kbd_strobe,
    output logic [6:0]         kbd_code,
    output logic               kbd_release,
    output logic [2:0]         mouse_buttons,
    output logic [MOUSE_W-1:0] mouse_dx,
    output logic [MOUSE_W-1:0] mouse_dy,
    input  logic               mouse_clr,
    output logic [7:0]         joy0,
    output logic [7:0]         joy1
);

    typedef enum logic [7:0] {
        CMD_STATUS   = 8'h00,
        CMD_KEYBOARD = 8'h01,
        CMD_MOUSE    = 8'h02,
        CMD_JOYSTICK = 8'h03
    } cmd_e;

    logic [7:0]         cmd_q, cmd_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [7:0]         idx_q, idx_d;
    logic [7:0]         data_out_q, data_out_d;
    logic               kbd_strobe_q, kbd_strobe_d;
    logic [6:0]         kbd_code_q, kbd_code_d;
    logic               kbd_release_q, kbd_release_d;
    logic [2:0]         buttons_q, buttons_d;
    logic [MOUSE_W-1:0] dx_q, dx_d;
    logic [MOUSE_W-1:0] dy_q, dy_d;
    logic [7:0]         joy0_q, joy0_d;
    logic [7:0]         joy1_q, joy1_d;

    // Signed add of an 8-bit delta, clamped to the accumulator range.
    // One extra bit of sum width exposes overflow as a sign-bit mismatch.
    function automatic logic [MOUSE_W-1:0] sat_add(input logic [MOUSE_W-1:0] acc,
                                                   input logic [7:0]         delta);
        logic [MOUSE_W:0] sum;
        sum = {acc[MOUSE_W-1], acc} + {{(MOUSE_W-7){delta[7]}}, delta};
        if (sum[MOUSE_W] != sum[MOUSE_W-1])
            sat_add = sum[MOUSE_W] ? {1'b1, {(MOUSE_W-1){1'b0}}}
                                   : {1'b0, {(MOUSE_W-1){1'b1}}};
        else
            sat_add = sum[MOUSE_W-1:0];
    endfunction

    always_comb begin
        cmd_d         = cmd_q;
        cnt_d         = cnt_q;
        idx_d         = idx_q;
        data_out_d    = data_out_q;
        kbd_strobe_d  = 1'b0;
        kbd_code_d    = kbd_code_q;
        kbd_release_d = kbd_release_q;
        buttons_d     = buttons_q;
        joy0_d        = joy0_q;
        joy1_d        = joy1_q;
        // Clear acts first so a coincident accumulate starts from zero.
        dx_d          = mouse_clr ? '0 : dx_q;
        dy_d          = mouse_clr ? '0 : dy_q;

        if (hid.data_in_strobe) begin
            if (hid.data_in_start) begin
                cmd_d      = hid.data_in;
                cnt_d      = 4'd1;
                data_out_d = (hid.data_in == 8'h00) ? VERSION : 8'h00;
            end else begin
                data_out_d = 8'h00;
                cnt_d      = (cnt_q == 4'd15) ? cnt_q : cnt_q + 4'd1;
                case (cmd_q)
                    CMD_STATUS: begin
                        if (cnt_q == 4'd1)
                            data_out_d = {5'b0, joy1_q != '0, joy0_q != '0,
                                          (dx_q != '0) || (dy_q != '0)};
                    end
                    CMD_KEYBOARD: begin
                        if (cnt_q == 4'd1) begin
                            kbd_code_d    = hid.data_in[6:0];
                            kbd_release_d = hid.data_in[7];
                            kbd_strobe_d  = 1'b1;
                        end
                    end
                    CMD_MOUSE: begin
                        if (cnt_q == 4'd1) buttons_d = hid.data_in[2:0];
                        if (cnt_q == 4'd2) dx_d = sat_add(dx_d, hid.data_in);
                        if (cnt_q == 4'd3) dy_d = sat_add(dy_d, hid.data_in);
                    end
                    CMD_JOYSTICK: begin
                        if (cnt_q == 4'd1) idx_d = hid.data_in;
                        if (cnt_q == 4'd2) begin
                            if (idx_q == 8'd0) joy0_d = hid.data_in;
                            if (idx_q == 8'd1) joy1_d = hid.data_in;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cmd_q         <= 8'hFF;
            cnt_q         <= '0;
            idx_q         <= '0;
            data_out_q    <= '0;
            kbd_strobe_q  <= 1'b0;
            kbd_code_q    <= '0;
            kbd_release_q <= 1'b0;
            buttons_q     <= '0;
            dx_q          <= '0;
            dy_q          <= '0;
            joy0_q        <= '0;
            joy1_q        <= '0;
        end else begin
            cmd_q         <= cmd_d;
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            data_out_q    <= data_out_d;
            kbd_strobe_q  <= kbd_strobe_d;
            kbd_code_q    <= kbd_code_d;
            kbd_release_q <= kbd_release_d;
            buttons_q     <= buttons_d;
            dx_q          <= dx_d;
            dy_q          <= dy_d;
            joy0_q        <= joy0_d;
            joy1_q        <= joy1_d;
        end
    end

    assign hid.data_out  = data_out_q;
    assign kbd_strobe    = kbd_strobe_q;
    assign kbd_code      = kbd_code_q;
    assign kbd_release   = kbd_release_q;
    assign mouse_buttons = buttons_q;
    assign mouse_dx      = dx_q;
    assign mouse_dy      = dy_q;
    assign joy0          = joy0_q;
    assign joy1          = joy1_q;

endmodule
